alu_uart_interface: RTL and testbench
=====================================

Name: alu_uart_interface

Overview:
Sequential front end that drives the combinational MIPS-subset ALU from a byte-wide UART link. It collects three received bytes in order: operand A, operand B, then the opcode. It presents them to the ALU, captures the ALU result and hands it to the UART transmitter as one byte. It sits between uart_rx/uart_tx and the ALU in the board-level top.

Parameters:
- NB_DATA, 8, operand/result width; fixed at 8 because the link is byte-wide.
- NB_OP, 6, ALU opcode width.
- TIMEOUT_CYCLES, 1000000, idle clock cycles allowed in GET_B, GET_OP or WAIT_TX before the interface aborts back to GET_A. Minimum 2.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  8  byte from the UART receiver; valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse: a new byte is on i_rx_data.
- i_tx_done  in  1  one-cycle pulse: the transmitter finished the current byte.
- i_alu_result  in  NB_DATA  combinational result from the ALU.
- o_alu_data_A  out  NB_DATA  registered operand A to the ALU.
- o_alu_data_B  out  NB_DATA  registered operand B to the ALU.
- o_alu_op  out  NB_OP  registered opcode to the ALU.
- o_tx_data  out  8  result byte to the transmitter.
- o_tx_start  out  1  one-cycle registered pulse that starts transmission.
- o_busy  out  1  high in EXEC, SEND and WAIT_TX.
- o_timeout  out  1  one-cycle registered pulse when a timeout abort occurs.

Behaviour:
- Reset (async assert, sync release) gives: state=GET_A, A=0x00, B=0x00, op=6'b111111 (ALU idle op, result 0), o_tx_data=0x00, o_tx_start=0, o_busy=0, o_timeout=0, timer=0.
- Reset asserted mid-transaction discards all partial data immediately.
- States and transitions:
  - GET_A: on i_rx_done, A<=i_rx_data, go to GET_B. No timeout in this state.
  - GET_B: on i_rx_done, B<=i_rx_data, go to GET_OP.
  - GET_OP: on i_rx_done, op<=i_rx_data[NB_OP-1:0] (bits 7:6 ignored), go to EXEC.
  - EXEC: lasts exactly one cycle. o_tx_data<=i_alu_result, which is already settled from the registered A/B/op. Go to SEND.
  - SEND: lasts one cycle. o_tx_start=1 during this cycle only. Go to WAIT_TX.
  - WAIT_TX: on i_tx_done, go to GET_A.
- Latency: i_rx_done for the opcode byte sampled at edge n. EXEC occupies cycle n..n+1, o_tx_data is valid after edge n+1, o_tx_start is high from edge n+1 to edge n+2.
- A, B and op hold their values after a transaction and after a timeout. They change only when a new byte is loaded into them.
- i_rx_done in EXEC, SEND or WAIT_TX: the byte is dropped and no register changes.
- i_tx_done outside WAIT_TX: ignored.
- Timer:
  - Cleared on every state change and on every accepted byte.
  - Increments each cycle spent in GET_B, GET_OP or WAIT_TX.
  - When timer==TIMEOUT_CYCLES-1 and no qualifying event occurs in that cycle: go to GET_A, pulse o_timeout for the next cycle, clear timer.
- Simultaneous events: if i_rx_done (or i_tx_done in WAIT_TX) arrives in the same cycle the timer expires, the event wins and no timeout is raised.
- No arithmetic in the block. The result byte is passed through unchanged, including the ALU default code 0xA1 for an unknown op.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 with an ALU model attached -> o_alu_op=6'b100000; one o_tx_start pulse one cycle after EXEC; o_tx_data=0x08. Then i_tx_done -> o_busy=0, state GET_A.
- Bytes 0x03, 0x05, 0xE2 -> o_alu_op=6'b100010 (upper bits stripped); o_tx_data=0xFE.
- Bytes 0xF0, 0x00, 0x03 (SRA, shamt 0) then op 0x3F -> result 0xF0, then 0x00. Unknown op 0x3E -> o_tx_data=0xA1.
- TIMEOUT_CYCLES=16: send 0x11, then silence for 16 cycles -> single o_timeout pulse, back in GET_A, o_alu_data_A still 0x11. Next three bytes complete a normal transaction.
- While in WAIT_TX, pulse i_rx_done with 0x77 -> no register change, no extra o_tx_start. i_rx_done coinciding with the timer expiry cycle -> byte accepted, no o_timeout.
- Assert i_rst_n=0 asynchronously in GET_OP and again during SEND -> all outputs return to reset values within the same cycle, and no o_tx_start pulse appears.

Source files
------------

// File: rtl/alu_uart_interface.sv
// Byte-serial front end for the ALU: receives A, B and opcode over the UART link,
// lets the ALU settle for one cycle, then hands the result byte to the transmitter.
module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_data_A,
  output logic [NB_DATA-1:0] o_alu_data_B,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [2:0]         o_dbg_state
);

  // Handshake: i_rx_done / i_tx_done are single-cycle strobes with no backpressure;
  // a strobe counts only in the state that expects it and is otherwise dropped.
  // o_tx_start is a single-cycle strobe the transmitter must accept unconditionally.

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t             state_q;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               timeout_q;
  logic [TW-1:0]      timer_q;

  logic timer_expired;
  assign timer_expired = (timer_q == TIMER_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= GET_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '1;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        GET_A: begin
          timer_q <= '0;
          if (i_rx_done) begin
            a_q     <= i_rx_data;
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (i_rx_done) begin
            b_q     <= i_rx_data;
            timer_q <= '0;
            state_q <= GET_OP;
          end else if (timer_expired) begin
            timer_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= GET_A;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        GET_OP: begin
          if (i_rx_done) begin
            op_q    <= i_rx_data[NB_OP-1:0];
            timer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end else if (timer_expired) begin
            timer_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= GET_A;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        EXEC: begin
          // Operands were registered last edge, so the ALU output is settled now.
          tx_data_q  <= i_alu_result;
          tx_start_q <= 1'b1;
          timer_q    <= '0;
          state_q    <= SEND;
        end
        SEND: begin
          timer_q <= '0;
          state_q <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            timer_q <= '0;
            busy_q  <= 1'b0;
            state_q <= GET_A;
          end else if (timer_expired) begin
            timer_q   <= '0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= GET_A;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          timer_q <= '0;
          busy_q  <= 1'b0;
          state_q <= GET_A;
        end
      endcase
    end
  end

  assign o_alu_data_A = a_q;
  assign o_alu_data_B = b_q;
  assign o_alu_op     = op_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_busy       = busy_q;
  assign o_timeout    = timeout_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a reference ALU on the result path
// and a scoreboard that checks every transmitted byte and timeout pulse.
module tb_alu_uart_interface;

  localparam logic [2:0] S_GET_A   = 3'd0;
  localparam logic [2:0] S_GET_B   = 3'd1;
  localparam logic [2:0] S_GET_OP  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       timeout;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  int         exp_timeouts;
  int         n_vec;
  int         n_err;

  alu_uart_interface #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_tx_done(tx_done),
    .i_alu_result(alu_result),
    .o_alu_data_A(alu_a),
    .o_alu_data_B(alu_b),
    .o_alu_op(alu_op),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_busy(busy),
    .o_timeout(timeout),
    .o_dbg_state(dbg_state)
  );

  // Reference MIPS-subset ALU driving the result input.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      6'b111111: return 8'h00;
      default:   return 8'hA1;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every tx_start must match the next queued result byte.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_tx_start", 32'd1, 32'd0);
      else check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
    if (timeout === 1'b1) begin
      if (exp_timeouts == 0) check("unexpected_timeout", 32'd1, 32'd0);
      else begin
        exp_timeouts--;
        n_vec++;
      end
    end
  end

  // Driver tasks: all called at a falling edge, return at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, {29'd0, dbg_state}, {29'd0, S_GET_A});
    check({tag, "_A"}, {24'd0, alu_a}, 32'h00);
    check({tag, "_B"}, {24'd0, alu_b}, 32'h00);
    check({tag, "_op"}, {26'd0, alu_op}, 32'h3F);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'h00);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
  endtask

  // Full transaction up to WAIT_TX, checking cycle-exact latency along the way.
  task automatic run_to_wait(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input logic [5:0] exp_op, input logic [7:0] exp_res);
    send_byte(a);
    send_byte(b);
    exp_q.push_back(exp_res);
    send_byte(op);
    check("exec_state", {29'd0, dbg_state}, {29'd0, S_EXEC});
    check("exec_busy", {31'd0, busy}, 32'd1);
    check("alu_A", {24'd0, alu_a}, {24'd0, a});
    check("alu_B", {24'd0, alu_b}, {24'd0, b});
    check("alu_op", {26'd0, alu_op}, {26'd0, exp_op});
    @(negedge clk);
    check("send_state", {29'd0, dbg_state}, {29'd0, S_SEND});
    check("send_tx_start", {31'd0, tx_start}, 32'd1);
    @(negedge clk);
    check("wait_state", {29'd0, dbg_state}, {29'd0, S_WAIT_TX});
    check("wait_tx_start", {31'd0, tx_start}, 32'd0);
  endtask

  task automatic finish_txn();
    pulse_tx_done();
    check("done_state", {29'd0, dbg_state}, {29'd0, S_GET_A});
    check("done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_timeouts = 0;
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ADD, SUB with stripped upper bits, SRA by zero, idle op, unknown op
    run_to_wait(8'h05, 8'h03, 8'h20, 6'b100000, 8'h08);
    finish_txn();
    run_to_wait(8'h03, 8'h05, 8'hE2, 6'b100010, 8'hFE);
    finish_txn();
    run_to_wait(8'hF0, 8'h00, 8'h03, 6'b000011, 8'hF0);
    finish_txn();
    run_to_wait(8'hF0, 8'h00, 8'h3F, 6'b111111, 8'h00);
    finish_txn();
    run_to_wait(8'hF0, 8'h00, 8'h3E, 6'b111110, 8'hA1);
    finish_txn();

    // Timeout in GET_B: 16 idle cycles after A, A retained
    send_byte(8'h11);
    repeat (15) @(negedge clk);
    check("pre_timeout_state", {29'd0, dbg_state}, {29'd0, S_GET_B});
    check("pre_timeout_pulse", {31'd0, timeout}, 32'd0);
    exp_timeouts++;
    @(negedge clk);
    check("timeout_pulse", {31'd0, timeout}, 32'd1);
    check("timeout_state", {29'd0, dbg_state}, {29'd0, S_GET_A});
    check("timeout_keep_A", {24'd0, alu_a}, 32'h11);
    @(negedge clk);
    check("timeout_single", {31'd0, timeout}, 32'd0);
    run_to_wait(8'h0C, 8'h0A, 8'h24, 6'b100100, 8'h08);

    // Stray byte in WAIT_TX is dropped
    send_byte(8'h77);
    check("drop_A", {24'd0, alu_a}, 32'h0C);
    check("drop_B", {24'd0, alu_b}, 32'h0A);
    check("drop_op", {26'd0, alu_op}, 32'h24);
    check("drop_state", {29'd0, dbg_state}, {29'd0, S_WAIT_TX});
    finish_txn();

    // Byte arriving in the expiry cycle wins over the timeout
    send_byte(8'h22);
    repeat (15) @(negedge clk);
    send_byte(8'h33);
    check("race_state", {29'd0, dbg_state}, {29'd0, S_GET_OP});
    check("race_B", {24'd0, alu_b}, 32'h33);
    check("race_no_timeout", {31'd0, timeout}, 32'd0);
    exp_q.push_back(8'h55);
    send_byte(8'h20);
    repeat (2) @(negedge clk);
    finish_txn();

    // Timeout in WAIT_TX
    run_to_wait(8'h0F, 8'hF0, 8'h25, 6'b100101, 8'hFF);
    repeat (15) @(negedge clk);
    check("wait_pre_timeout", {31'd0, busy}, 32'd1);
    exp_timeouts++;
    @(negedge clk);
    check("wait_timeout_pulse", {31'd0, timeout}, 32'd1);
    check("wait_timeout_busy", {31'd0, busy}, 32'd0);
    check("wait_timeout_state", {29'd0, dbg_state}, {29'd0, S_GET_A});
    @(negedge clk);

    // Async reset in GET_OP
    send_byte(8'h44);
    send_byte(8'h55);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_getop");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset during SEND, before the monitor sees tx_start
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst_send");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_state", {29'd0, dbg_state}, {29'd0, S_GET_A});

    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("timeouts_seen", exp_timeouts, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
